piso_rr_sched: RTL and testbench



---
 rtl/piso_sched_pkg.sv | 8 +
 rtl/piso_rr_arbiter.sv | 31 +++
 rtl/piso_rr_sched.sv | 101 ++++++++++
 tb/tb_piso_rr_sched.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/piso_sched_pkg.sv
// Shared types and default sizes for the round-robin PISO scheduler.
// Optional parity bit is enabled by defining PISO_SCHED_PARITY_EN.
package piso_sched_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, PAR} sched_state_e;

   localparam int NUM_REQ_DEF = 4;
   localparam int DATA_W_DEF  = 4;
endpackage

// File: rtl/piso_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr_i,
// wrapping from NUM_REQ-1 back to 0. No grant when en_i is low.
module piso_rr_arbiter #(
   parameter  int NUM_REQ = 4,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [IDW-1:0]     ptr_i,
   input  logic               en_i,
   output logic [NUM_REQ-1:0] gnt_o,
   output logic [IDW-1:0]     gnt_id_o
);
   int   idx;
   logic found;

   always_comb begin
      gnt_o    = '0;
      gnt_id_o = '0;
      found    = 1'b0;
      idx      = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = int'(ptr_i) + i;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (en_i && !found && req_i[idx]) begin
            found      = 1'b1;
            gnt_o[idx] = 1'b1;
            gnt_id_o   = IDW'(idx);
         end
      end
   end
endmodule

// File: rtl/piso_rr_sched.sv
// One shared PISO shift engine serving NUM_REQ requesters round-robin, LSB first.
// Define PISO_SCHED_PARITY_EN to append an even-parity bit to every frame.
module piso_rr_sched
   import piso_sched_pkg::*;
#(
   parameter  int NUM_REQ = NUM_REQ_DEF,
   parameter  int DATA_W  = DATA_W_DEF,
   localparam int IDW     = $clog2(NUM_REQ)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_i,
   input  logic [NUM_REQ*DATA_W-1:0] data_i,
   output logic [NUM_REQ-1:0]        gnt_o,
   output logic                      serial_o,
   output logic                      valid_o,
   output logic                      sof_o,
   output logic [IDW-1:0]            src_o,
   output logic                      busy_o
);
   localparam int CW = $clog2(DATA_W + 1);

   sched_state_e      state_q;
   logic [DATA_W-1:0] shreg_q;
   logic [CW-1:0]     cnt_q;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [IDW-1:0]    src_q;
   logic [IDW-1:0]    gnt_id;
   logic [DATA_W-1:0] win_word;
   logic              last_bit, elig, gnt_any;

   assign last_bit = (state_q == SHIFT) && (cnt_q == CW'(DATA_W - 1));

`ifdef PISO_SCHED_PARITY_EN
   logic par_q;
   assign elig = (state_q == IDLE) || (state_q == PAR);
`else
   assign elig = (state_q == IDLE) || last_bit;
`endif

   piso_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req_i    (req_i),
      .ptr_i    (ptr_q),
      .en_i     (elig && !reset),
      .gnt_o    (gnt_o),
      .gnt_id_o (gnt_id)
   );

   assign gnt_any  = |gnt_o;
   assign win_word = data_i[gnt_id*DATA_W +: DATA_W];
   assign ptr_d    = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
         ptr_q   <= '0;
         src_q   <= '0;
`ifdef PISO_SCHED_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else if (elig) begin
         // Grant on the closing cycle of a frame gives gap-free back-to-back frames.
         cnt_q <= '0;
         if (gnt_any) begin
            state_q <= SHIFT;
            shreg_q <= win_word;
            src_q   <= gnt_id;
            ptr_q   <= ptr_d;
`ifdef PISO_SCHED_PARITY_EN
            par_q   <= ^win_word;
`endif
         end else begin
            state_q <= IDLE;
            shreg_q <= '0;
         end
      end else if (state_q == SHIFT) begin
         shreg_q <= shreg_q >> 1;
`ifdef PISO_SCHED_PARITY_EN
         if (last_bit) state_q <= PAR;
         else          cnt_q   <= cnt_q + CW'(1);
`else
         cnt_q   <= cnt_q + CW'(1);
`endif
      end
   end

   always_comb begin
      serial_o = 1'b0;
      if (state_q == SHIFT) serial_o = shreg_q[0];
`ifdef PISO_SCHED_PARITY_EN
      if (state_q == PAR)   serial_o = par_q;
`endif
   end

   assign valid_o = (state_q != IDLE);
   assign busy_o  = (state_q != IDLE);
   assign sof_o   = (state_q == SHIFT) && (cnt_q == '0);
   assign src_o   = src_q;
endmodule

// File: tb/tb_piso_rr_sched.sv
// Randomized bench for piso_rr_sched against a frame-queue reference model.
// Honours PISO_SCHED_PARITY_EN to expect the trailing parity bit.
module tb_piso_rr_sched;
   localparam int N  = 4;
   localparam int DW = 4;
`ifdef PISO_SCHED_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            reset;
   logic [N-1:0]    req_i;
   logic [N*DW-1:0] data_i;
   logic [N-1:0]    gnt_o;
   logic            serial_o, valid_o, sof_o, busy_o;
   logic [1:0]      src_o;

   piso_rr_sched #(.NUM_REQ(N), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset), .req_i(req_i), .data_i(data_i),
      .gnt_o(gnt_o), .serial_o(serial_o), .valid_o(valid_o),
      .sof_o(sof_o), .src_o(src_o), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model: a queue of the bits the link still owes, one entry per cycle.
   typedef struct {logic ser; logic sof; logic [1:0] src;} lbit_t;
   lbit_t      q[$];
   int         m_ptr = 0;
   logic [1:0] m_src = '0;

   task automatic model_reset();
      q.delete();
      m_ptr = 0;
      m_src = '0;
   endtask

   // Check one cycle at negedge, advance model, return at posedge+1.
   task automatic step(output int win);
      logic [DW-1:0] w;
      lbit_t e;
      @(negedge clk);
      win = -1;
      if (q.size() <= 1)
         for (int i = 0; i < N; i++)
            if (win < 0 && req_i[(m_ptr + i) % N]) win = (m_ptr + i) % N;
      chk("gnt", 32'(gnt_o), (win >= 0) ? (32'd1 << win) : 32'd0);
      if (q.size() > 0) begin
         chk("serial", 32'(serial_o), 32'(q[0].ser));
         chk("valid",  32'(valid_o),  32'd1);
         chk("sof",    32'(sof_o),    32'(q[0].sof));
         chk("src",    32'(src_o),    32'(q[0].src));
         chk("busy",   32'(busy_o),   32'd1);
         void'(q.pop_front());
      end else begin
         chk("serial_idle", 32'(serial_o), 32'd0);
         chk("valid_idle",  32'(valid_o),  32'd0);
         chk("sof_idle",    32'(sof_o),    32'd0);
         chk("src_idle",    32'(src_o),    32'(m_src));
         chk("busy_idle",   32'(busy_o),   32'd0);
      end
      if (win >= 0) begin
         w = data_i[win*DW +: DW];
         for (int b = 0; b < DW; b++) begin
            e.ser = w[b]; e.sof = (b == 0); e.src = 2'(win);
            q.push_back(e);
         end
         if (PAR_EN) begin
            e.ser = ^w; e.sof = 1'b0; e.src = 2'(win);
            q.push_back(e);
         end
         m_ptr = (win + 1) % N;
         m_src = 2'(win);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      int win;
      logic [N-1:0]  pend;
      logic [DW-1:0] wd [N];

      reset = 1'b1; req_i = '0; data_i = '0;
      #1;
      chk("rst_gnt",    32'(gnt_o),    0);
      chk("rst_serial", 32'(serial_o), 0);
      chk("rst_valid",  32'(valid_o),  0);
      chk("rst_sof",    32'(sof_o),    0);
      chk("rst_src",    32'(src_o),    0);
      chk("rst_busy",   32'(busy_o),   0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // Single request from 2, word 1011.
      req_i = 4'b0100; data_i = 16'h0B00;
      step(win);
      chk("single_win", 32'(win), 2);
      req_i = '0;
      repeat (DW + 3) step(win);

      // All requests held: rotation 3 (ptr after 2),0,1,2,3 and gap-free frames.
      req_i = 4'b1111; data_i = {4'd4, 4'd3, 4'd2, 4'd1};
      for (int f = 0; f < 6; f++) begin
         step(win);
         chk("rot_win", 32'(win), 32'((3 + f) % N));
         repeat (DW - 1 + int'(PAR_EN)) step(win);
      end
      req_i = '0;
      repeat (DW + 2) step(win);

      // Reset during bit 2 of a frame.
      req_i = 4'b0001;
      step(win); req_i = '0;
      step(win); step(win);
      req_i = 4'b0011;
      reset = 1'b1;
      #1;
      chk("mid_gnt",    32'(gnt_o),    0);
      chk("mid_serial", 32'(serial_o), 0);
      chk("mid_valid",  32'(valid_o),  0);
      chk("mid_sof",    32'(sof_o),    0);
      chk("mid_src",    32'(src_o),    0);
      chk("mid_busy",   32'(busy_o),   0);
      model_reset();
      @(posedge clk);
      #1;
      chk("rst_hold_gnt", 32'(gnt_o), 0);
      reset = 1'b0;
      step(win);
      chk("post_rst_win", 32'(win), 0);
      req_i = '0;
      repeat (DW + 2) step(win);

      // Random traffic: requests hold until granted, occasionally withdrawn.
      pend = '0;
      for (int k = 0; k < N; k++) wd[k] = '0;
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < N; k++) begin
            if (!pend[k] && $urandom_range(0, 3) == 0) begin
               pend[k] = 1'b1;
               wd[k]   = DW'($urandom);
            end else if (pend[k] && $urandom_range(0, 15) == 0) begin
               pend[k] = 1'b0;
            end
         end
         req_i = pend;
         for (int k = 0; k < N; k++) data_i[k*DW +: DW] = wd[k];
         step(win);
         if (win >= 0) pend[win] = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
